// File: rtl/rw_array_clr.sv
// rtl/rw_array_clr.sv - register array with write-first read port and sequential clear sweep
// Optional RW_ARRAY_WMASK_EN adds a per-bit write mask port (wmask).
module rw_array_clr #(
  parameter int S_INDEX = 3,
  parameter int WIDTH   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               read,
  input  logic               load,
  input  logic [S_INDEX-1:0] rindex,
  input  logic [S_INDEX-1:0] windex,
  input  logic [WIDTH-1:0]   datain,
`ifdef RW_ARRAY_WMASK_EN
  input  logic [WIDTH-1:0]   wmask,
`endif
  input  logic               clear,
  output logic               busy,
  output logic [WIDTH-1:0]   dataout,
  output logic               dataout_valid
);

  localparam int N = 2 ** S_INDEX;
  localparam logic [S_INDEX-1:0] LAST_INDEX = {S_INDEX{1'b1}};

  localparam logic STATE_SWEEP = 1'b0;
  localparam logic STATE_IDLE  = 1'b1;

  logic               state;
  logic [S_INDEX-1:0] cnt;
  logic [WIDTH-1:0]   mem [N];

  logic               is_idle;
  logic               do_load;
  logic               do_read;
  logic [WIDTH-1:0]   bit_mask;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH-1:0]   rd_data;

`ifdef RW_ARRAY_WMASK_EN
  assign bit_mask = wmask;
`else
  assign bit_mask = {WIDTH{1'b1}};
`endif

  assign is_idle = (state == STATE_IDLE);
  assign busy    = ~is_idle;

  // A clear in the same cycle discards the load, so it must not feed the bypass either.
  assign do_load = is_idle & load & ~clear;
  assign do_read = is_idle & read;

  assign wr_data = (datain & bit_mask) | (mem[windex] & ~bit_mask);
  assign rd_data = (do_load && (windex == rindex)) ? wr_data : mem[rindex];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= STATE_SWEEP;
      cnt           <= '0;
      dataout       <= '0;
      dataout_valid <= 1'b0;
    end else begin
      case (state)
        STATE_SWEEP: begin
          cnt           <= cnt + S_INDEX'(1);
          dataout_valid <= 1'b0;
          if (cnt == LAST_INDEX) begin
            state <= STATE_IDLE;
          end
        end
        default: begin
          // A read coinciding with clear still completes; validity drops on the next edge.
          if (do_read) begin
            dataout       <= rd_data;
            dataout_valid <= 1'b1;
          end else if (clear) begin
            dataout_valid <= 1'b0;
          end
          if (clear) begin
            state <= STATE_SWEEP;
          end
        end
      endcase
    end
  end

  // Storage has no reset; it is zeroed only by the sweep.
  always_ff @(posedge clk) begin
    if (state == STATE_SWEEP) begin
      mem[cnt] <= '0;
    end else if (do_load) begin
      mem[windex] <= wr_data;
    end
  end

endmodule
